// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC front end: mode encodings, the quadrant
// decision code and the quarter-turn angle constant.
package cordic_pkg;

  localparam logic MODE_VECTOR = 1'b0;
  localparam logic MODE_ROTATE = 1'b1;

  // ROT_P90: x' = y, y' = -x.  ROT_M90: x' = -y, y' = x.
  typedef enum logic [1:0] {
    PASS    = 2'b00,
    ROT_P90 = 2'b01,
    ROT_M90 = 2'b10
  } dec_e;

  function automatic logic [63:0] ANGLE_90(input int unsigned aw);
    ANGLE_90 = 64'd1 << (aw - 32'd2);
  endfunction

endpackage

// File: rtl/qp_negsat.sv
// Saturating two's-complement negate: the most negative value maps to the
// most positive one and raises sat_o.
module qp_negsat #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] neg_o,
  output logic         sat_o
);

  logic [W-1:0] min_s;
  logic [W-1:0] max_s;

  assign min_s = {1'b1, {(W-1){1'b0}}};
  assign max_s = {1'b0, {(W-1){1'b1}}};

  // Negate, clamping the one value whose negation is not representable.
  always_comb begin
    neg_o = {W{1'b0}};
    sat_o = 1'b0;
    if (a_i == min_s) begin
      neg_o = max_s;
      sat_o = 1'b1;
    end else begin
      neg_o = {W{1'b0}} - a_i;
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/quadrant_prerotator.sv
// Two-stage quadrant pre-rotation ahead of the CORDIC core: S1 decodes the
// quadrant and fixes the angle, S2 applies the swap/negate with saturation.
module quadrant_prerotator
  import cordic_pkg::*;
#(
  parameter int W  = 32,
  parameter int AW = 32,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_y,
  input  logic [AW-1:0] in_angle,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_x,
  output logic [W-1:0]  out_y,
  output logic [AW-1:0] out_angle,
  output logic          out_mode,
  output logic [TW-1:0] out_tag,
  output logic          out_sat
);

  localparam logic [AW-1:0] A90 = AW'(ANGLE_90(AW));

  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  logic          s1_load_s, s2_load_s;

  logic          s1_mode_q;
  logic [W-1:0]  s1_x_q, s1_y_q;
  logic [TW-1:0] s1_tag_q;
  dec_e          s1_dec_q, dec_d;
  logic [AW-1:0] s1_angle_q, angle_d, base_s;

  logic [W-1:0]  out_x_q, out_y_q, x_d, y_d;
  logic [AW-1:0] out_angle_q;
  logic          out_mode_q, out_sat_q, sat_d;
  logic [TW-1:0] out_tag_q;

  logic [W-1:0]  neg_x_s, neg_y_s;
  logic          sat_x_s, sat_y_s;

  assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;

  // Stage occupancy: a stage loads when empty or when it drains this cycle.
  always_comb begin
    s2_load_s  = s1_valid_q & (~s2_valid_q | out_ready);
    s1_load_s  = in_valid & in_ready;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_load_s) begin
      s1_valid_d = 1'b1;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_load_s) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Quadrant decision; VECTOR offsets start from zero, ROTATE from the input angle.
  always_comb begin
    dec_d   = PASS;
    base_s  = {AW{1'b0}};
    angle_d = {AW{1'b0}};
    if (in_mode == MODE_VECTOR) begin
      base_s = {AW{1'b0}};
      if (!in_x[W-1]) begin
        dec_d = PASS;
      end else if (!in_y[W-1]) begin
        dec_d = ROT_P90;
      end else begin
        dec_d = ROT_M90;
      end
    end else begin
      base_s = in_angle;
      case (in_angle[AW-1:AW-2])
        2'b01:   dec_d = ROT_M90;
        2'b10:   dec_d = ROT_P90;
        default: dec_d = PASS;
      endcase
    end
    case (dec_d)
      ROT_P90: angle_d = base_s + A90;
      ROT_M90: angle_d = base_s - A90;
      default: angle_d = base_s;
    endcase
  end

  qp_negsat #(.W(W)) u_neg_x (
    .a_i   (s1_x_q),
    .neg_o (neg_x_s),
    .sat_o (sat_x_s)
  );

  qp_negsat #(.W(W)) u_neg_y (
    .a_i   (s1_y_q),
    .neg_o (neg_y_s),
    .sat_o (sat_y_s)
  );

  // Swap/negate selection; only the negation actually used can flag saturation.
  always_comb begin
    x_d   = s1_x_q;
    y_d   = s1_y_q;
    sat_d = 1'b0;
    case (s1_dec_q)
      ROT_P90: begin
        x_d   = s1_y_q;
        y_d   = neg_x_s;
        sat_d = sat_x_s;
      end
      ROT_M90: begin
        x_d   = neg_y_s;
        y_d   = s1_x_q;
        sat_d = sat_y_s;
      end
      default: begin
        x_d   = s1_x_q;
        y_d   = s1_y_q;
        sat_d = 1'b0;
      end
    endcase
  end

  // Pipeline registers; data fields change only when their stage loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_x_q      <= {W{1'b0}};
      s1_y_q      <= {W{1'b0}};
      s1_tag_q    <= {TW{1'b0}};
      s1_dec_q    <= PASS;
      s1_angle_q  <= {AW{1'b0}};
      out_x_q     <= {W{1'b0}};
      out_y_q     <= {W{1'b0}};
      out_angle_q <= {AW{1'b0}};
      out_mode_q  <= 1'b0;
      out_tag_q   <= {TW{1'b0}};
      out_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load_s) begin
        s1_mode_q  <= in_mode;
        s1_x_q     <= in_x;
        s1_y_q     <= in_y;
        s1_tag_q   <= in_tag;
        s1_dec_q   <= dec_d;
        s1_angle_q <= angle_d;
      end
      if (s2_load_s) begin
        out_x_q     <= x_d;
        out_y_q     <= y_d;
        out_angle_q <= s1_angle_q;
        out_mode_q  <= s1_mode_q;
        out_tag_q   <= s1_tag_q;
        out_sat_q   <= sat_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_angle = out_angle_q;
  assign out_mode  = out_mode_q;
  assign out_tag   = out_tag_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_quadrant_prerotator.sv
// Scoreboard bench for quadrant_prerotator at W = AW = 16: directed vectors,
// a back-pressured stream, full-pipeline stall and mid-flight reset.
module tb_quadrant_prerotator;

  localparam int W  = 16;
  localparam int AW = 16;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [AW-1:0] ang;
    logic          mode;
    logic [TW-1:0] tag;
    logic          sat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_mode;
  logic [W-1:0]  in_x, in_y;
  logic [AW-1:0] in_angle;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready, out_mode, out_sat;
  logic [W-1:0]  out_x, out_y;
  logic [AW-1:0] out_angle;
  logic [TW-1:0] out_tag;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  logic done;

  quadrant_prerotator #(.W(W), .AW(AW), .TW(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_angle  (in_angle),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_angle (out_angle),
    .out_mode  (out_mode),
    .out_tag   (out_tag),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [AW-1:0] a, input logic m,
                              input logic [TW-1:0] t, input logic s);
    exp_t e;
    e.x = x; e.y = y; e.ang = a; e.mode = m; e.tag = t; e.sat = s;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [AW-1:0] a, input logic [TW-1:0] t);
    in_valid = 1'b1; in_mode = m; in_x = x; in_y = y; in_angle = a; in_tag = t;
  endtask

  // Present one transaction, wait (bounded) for acceptance, record its expectation.
  task automatic send(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [AW-1:0] a, input logic [TW-1:0] t, input exp_t e);
    int n;
    @(negedge clk);
    drive(m, x, y, a, t);
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout tag=%0d in_ready=%b required=1", t, in_ready);
      in_valid = 1'b0;
    end else begin
      sb_q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: compare each emitted transaction in order, and check hold under stall.
  initial begin : monitor
    exp_t act, snap, e;
    logic have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      act = mk(out_x, out_y, out_angle, out_mode, out_tag, out_sat);
      if (reset) begin
        have = 1'b0;
      end else begin
        if (have) chk("stall_hold", 64'(act), 64'(snap));
        have = 1'b0;
        if (out_valid && !out_ready) begin
          snap = act;
          have = 1'b1;
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_output actual=%h required=none", act);
          end else begin
            e = sb_q.pop_front();
            chk("output", 64'(act), 64'(e));
          end
        end
      end
    end
  end

  logic [15:0] pat;
  logic [W-1:0] sx, sy;

  initial begin : main
    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0;
    in_angle = '0; in_tag = '0; out_ready = 1'b1; done = 1'b0;
    pat = 16'b1011_0010_1110_0101;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'({out_x, out_y, out_angle, out_mode, out_tag, out_sat}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Latency: out_valid exactly two cycles after the accept cycle.
    send(1'b0, 16'hFF9C, 16'd50, 16'h1234, 4'd1, mk(16'd50, 16'd100, 16'h4000, 1'b0, 4'd1, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("latency_c1", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("latency_c2", 64'(out_valid), 64'd1);

    send(1'b0, 16'hFFFD, 16'hFFF9, 16'h0000, 4'd2, mk(16'd7, 16'hFFFD, 16'hC000, 1'b0, 4'd2, 1'b0));
    send(1'b0, 16'h8000, 16'd5, 16'h0000, 4'd3, mk(16'd5, 16'h7FFF, 16'h4000, 1'b0, 4'd3, 1'b1));
    send(1'b0, 16'd5, 16'hFFF7, 16'h7777, 4'd4, mk(16'd5, 16'hFFF7, 16'h0000, 1'b0, 4'd4, 1'b0));
    send(1'b0, 16'hFFFF, 16'h8000, 16'h0000, 4'd5, mk(16'h7FFF, 16'hFFFF, 16'hC000, 1'b0, 4'd5, 1'b1));
    send(1'b1, 16'd10, 16'd20, 16'h6000, 4'd6, mk(16'hFFEC, 16'd10, 16'h2000, 1'b1, 4'd6, 1'b0));
    send(1'b1, 16'd10, 16'd20, 16'h8000, 4'd7, mk(16'd20, 16'hFFF6, 16'hC000, 1'b1, 4'd7, 1'b0));
    send(1'b1, 16'd10, 16'd20, 16'hC000, 4'd8, mk(16'd10, 16'd20, 16'hC000, 1'b1, 4'd8, 1'b0));
    send(1'b1, 16'h8000, 16'd3, 16'h4000, 4'd9, mk(16'hFFFD, 16'h8000, 16'h0000, 1'b1, 4'd9, 1'b0));
    send(1'b1, 16'h8000, 16'd3, 16'h3FFF, 4'd10, mk(16'h8000, 16'd3, 16'h3FFF, 1'b1, 4'd10, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    drain("drain_directed");

    // Stream of 8 under pseudo-random back-pressure.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          sx = 16'(100 + i);
          sy = 16'(-i);
          if (i % 2 == 0)
            send(1'b0, sx, sy, 16'h5555, 4'(i), mk(sx, sy, 16'h0000, 1'b0, 4'(i), 1'b0));
          else
            send(1'b1, sx, sy, 16'(16'h4000 + i), 4'(i), mk(16'(i), sx, 16'(i), 1'b1, 4'(i), 1'b0));
        end
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 400 && !done; k++) begin
          @(posedge clk);
          #1;
          out_ready = pat[k % 16];
        end
      end
    join
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("drain_stream");

    // Full pipeline with out_ready low, then accept and emit together.
    @(negedge clk);
    out_ready = 1'b0;
    send(1'b0, 16'd1, 16'd2, 16'h0000, 4'd11, mk(16'd1, 16'd2, 16'h0000, 1'b0, 4'd11, 1'b0));
    send(1'b0, 16'd3, 16'd4, 16'h0000, 4'd12, mk(16'd3, 16'd4, 16'h0000, 1'b0, 4'd12, 1'b0));
    @(negedge clk);
    drive(1'b0, 16'hFFFB, 16'd6, 16'h0000, 4'd13);
    #1;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd1);
    sb_q.push_back(mk(16'd6, 16'd5, 16'h4000, 1'b0, 4'd13, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("still_full", 64'(out_valid), 64'd1);
    chk("still_full_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    drain("drain_full");

    // Reset with two transactions in flight and an input offered during reset.
    @(negedge clk);
    out_ready = 1'b0;
    send(1'b0, 16'd21, 16'd22, 16'h0000, 4'd14, mk(16'd21, 16'd22, 16'h0000, 1'b0, 4'd14, 1'b0));
    send(1'b1, 16'd23, 16'd24, 16'h6000, 4'd15, mk(16'hFFE8, 16'd23, 16'h2000, 1'b1, 4'd15, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 16'hFFF0, 16'd9, 16'h0000, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    sb_q.delete();
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_outputs", 64'({out_x, out_y, out_angle, out_mode, out_tag, out_sat}), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("midreset_flushed", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
